// File: rtl/sign_extend_8bit_pkg.sv
// Shared ID-stage definitions for offset extension: field and datapath widths
// and the datapath word type.
package sign_extend_8bit_pkg;

    localparam int OFFSET_W = 8;
    localparam int DATA_W   = 16;

    typedef logic [DATA_W-1:0] word_t;

endpackage : sign_extend_8bit_pkg

// File: rtl/sign_extend_comb.sv
// Pure combinational sign/zero extension of the low IN_WIDTH bits of a field
// to OUT_WIDTH bits. Reusable for any offset width narrower than the datapath.
module sign_extend_comb
    import sign_extend_8bit_pkg::*;
#(
    parameter int IN_WIDTH  = OFFSET_W,
    parameter int OUT_WIDTH = DATA_W
) (
    input  logic [IN_WIDTH-1:0]  data_i,
    input  logic                 zext_i,
    output logic [OUT_WIDTH-1:0] ext_o
);

    localparam int FILL_W = OUT_WIDTH - IN_WIDTH;

    if (IN_WIDTH >= OUT_WIDTH) begin : g_bad_width
        $error("sign_extend_comb: IN_WIDTH (%0d) must be less than OUT_WIDTH (%0d)",
               IN_WIDTH, OUT_WIDTH);
    end

    logic fill_bit;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        fill_bit = zext_i ? 1'b0 : data_i[IN_WIDTH-1];
        ext_o    = {{FILL_W{fill_bit}}, data_i};
    end

endmodule : sign_extend_comb

// File: rtl/sign_extend_8bit.sv
// ID-stage offset extender: extends the low byte of the C-type offset bus to
// a 16-bit word and registers it with a one-cycle valid strobe.
module sign_extend_8bit
    import sign_extend_8bit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              zext,
    input  logic [DATA_W-1:0] C_type_offset,
    output logic [DATA_W-1:0] C_type_extended,
    output logic              out_valid
);

    word_t ext_d;
    word_t ext_q;
    logic  valid_q;

    // Upper offset bits are deliberately dropped; stale values there never reach the output.
    logic unused_upper;
    assign unused_upper = ^C_type_offset[DATA_W-1:OFFSET_W];

    sign_extend_comb #(
        .IN_WIDTH  (OFFSET_W),
        .OUT_WIDTH (DATA_W)
    ) u_ext (
        .data_i (C_type_offset[OFFSET_W-1:0]),
        .zext_i (zext),
        .ext_o  (ext_d)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                ext_q <= ext_d;
            end
        end
    end

    assign C_type_extended = ext_q;
    assign out_valid       = valid_q;

endmodule : sign_extend_8bit

// File: tb/tb_sign_extend_8bit.sv
// Self-checking bench for sign_extend_8bit: directed cases from the test plan
// plus randomized traffic against an arithmetic reference model.
module tb_sign_extend_8bit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        zext = 1'b0;
    logic [15:0] C_type_offset = 16'h0000;
    logic [15:0] C_type_extended;
    logic        out_valid;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] exp_ext = 16'h0000;
    logic        exp_valid = 1'b0;

    sign_extend_8bit dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .zext            (zext),
        .C_type_offset   (C_type_offset),
        .C_type_extended (C_type_extended),
        .out_valid       (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 16'h%h, expected 16'h%h", tag, got, exp);
        end
    endtask

    // Reference: take the low byte as an integer, reinterpret as two's complement
    // unless unsigned mode is requested, then wrap to 16 bits.
    function automatic logic [15:0] ref_extend(input logic [15:0] off, input logic zx);
        int v;
        v = int'(off) % 256;
        if (!zx && v >= 128) v = v - 256;
        if (v < 0) v = v + 65536;
        return 16'(v);
    endfunction

    // Drive one cycle of inputs, advance one edge, update the model and compare.
    task automatic apply(input logic r, input logic v, input logic zx,
                         input logic [15:0] off, input string tag);
        rst           = r;
        in_valid      = v;
        zext          = zx;
        C_type_offset = off;
        @(posedge clk);
        #1;
        if (r) begin
            exp_ext   = 16'h0000;
            exp_valid = 1'b0;
        end else if (v) begin
            exp_ext   = ref_extend(off, zx);
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        check({tag, "_valid"}, {15'd0, out_valid}, {15'd0, exp_valid});
        check({tag, "_data"}, C_type_extended, exp_ext);
    endtask

    initial begin
        logic r, v, zx;
        logic [15:0] off;

        // Reset held with valid input present: reset must win.
        apply(1'b1, 1'b1, 1'b0, 16'h00FF, "reset0");
        apply(1'b1, 1'b1, 1'b0, 16'h00FF, "reset1");
        check("reset_const", C_type_extended, 16'h0000);

        // Directed extension cases and boundaries.
        apply(1'b0, 1'b1, 1'b0, 16'h00FF, "neg_ff");
        check("neg_ff_abs", C_type_extended, 16'hFFFF);
        apply(1'b0, 1'b1, 1'b0, 16'h0032, "pos_50");
        check("pos_50_abs", C_type_extended, 16'h0032);
        apply(1'b0, 1'b1, 1'b0, 16'h007F, "max_pos");
        check("max_pos_abs", C_type_extended, 16'h007F);
        apply(1'b0, 1'b1, 1'b0, 16'h0080, "min_neg");
        check("min_neg_abs", C_type_extended, 16'hFF80);
        apply(1'b0, 1'b1, 1'b0, 16'h0000, "zero");
        apply(1'b0, 1'b1, 1'b0, 16'hAB05, "stale_upper");
        check("stale_upper_abs", C_type_extended, 16'h0005);
        apply(1'b0, 1'b1, 1'b1, 16'h0080, "zext_80");
        check("zext_80_abs", C_type_extended, 16'h0080);
        apply(1'b0, 1'b1, 1'b1, 16'hFFFF, "zext_ff_upper");
        check("zext_ff_upper_abs", C_type_extended, 16'h00FF);

        // Back-to-back pipeline, then hold with valid low.
        apply(1'b0, 1'b1, 1'b0, 16'h0001, "pipe0");
        check("pipe0_abs", C_type_extended, 16'h0001);
        apply(1'b0, 1'b1, 1'b0, 16'h00FE, "pipe1");
        check("pipe1_abs", C_type_extended, 16'hFFFE);
        apply(1'b0, 1'b1, 1'b0, 16'h0040, "pipe2");
        check("pipe2_abs", C_type_extended, 16'h0040);
        apply(1'b0, 1'b0, 1'b0, 16'h00FF, "hold");
        check("hold_abs", C_type_extended, 16'h0040);
        check("hold_valid_abs", {15'd0, out_valid}, 16'h0000);

        // Reset mid-stream, then the first valid input after release.
        apply(1'b1, 1'b1, 1'b0, 16'h0090, "mid_reset");
        apply(1'b0, 1'b1, 1'b0, 16'h0090, "post_reset");
        check("post_reset_abs", C_type_extended, 16'hFF90);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 19) == 0);
            v   = ($urandom_range(0, 3) != 0);
            zx  = $urandom_range(0, 1) == 1;
            off = 16'($urandom);
            apply(r, v, zx, off, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_sign_extend_8bit
